// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: one requester's request/response handshake toward the RAM arbiter
interface ram_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_wr_en;
  logic [DATA_WIDTH-1:0] req_wr_data;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  modport master (
    output req_valid, req_addr, req_wr_en, req_wr_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );
  modport slave (
    input  req_valid, req_addr, req_wr_en, req_wr_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin sharing of a single-port RAM between fetch (p0) and load/store (p1)
module ram_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ram_arbiter_if.slave          p0,
  ram_arbiter_if.slave          p1,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  mem_wr_en,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);
  logic                  last_grant_q, last_grant_d;
  logic                  rsp_valid0_q, rsp_valid0_d, rsp_valid1_q, rsp_valid1_d;
  logic [DATA_WIDTH-1:0] rsp_data0_q, rsp_data0_d, rsp_data1_q, rsp_data1_d;
  logic                  elig0, elig1, gnt0, gnt1, rd0, rd1;
  assign p0.req_ready = gnt0;
  assign p1.req_ready = gnt1;
  assign p0.rsp_valid = rsp_valid0_q;
  assign p1.rsp_valid = rsp_valid1_q;
  assign p0.rsp_data  = rsp_data0_q;
  assign p1.rsp_data  = rsp_data1_q;
  // Eligibility (gated by reset so nothing is granted while held in reset), round-robin grant, RAM mux, next response state
  always_comb begin
    elig0        = rst_n && p0.req_valid && (p0.req_wr_en || !rsp_valid0_q || p0.rsp_ready);
    elig1        = rst_n && p1.req_valid && (p1.req_wr_en || !rsp_valid1_q || p1.rsp_ready);
    gnt0         = elig0 && (!elig1 || last_grant_q);
    gnt1         = elig1 && (!elig0 || !last_grant_q);
    rd0          = gnt0 && !p0.req_wr_en;
    rd1          = gnt1 && !p1.req_wr_en;
    mem_addr     = gnt0 ? p0.req_addr    : gnt1 ? p1.req_addr    : '0;
    mem_wr_data  = gnt0 ? p0.req_wr_data : gnt1 ? p1.req_wr_data : '0;
    mem_wr_en    = gnt0 ? p0.req_wr_en   : gnt1 && p1.req_wr_en;
    last_grant_d = gnt0 ? 1'b0 : gnt1 ? 1'b1 : last_grant_q;
    rsp_valid0_d = rd0 || (rsp_valid0_q && !p0.rsp_ready);
    rsp_valid1_d = rd1 || (rsp_valid1_q && !p1.rsp_ready);
    rsp_data0_d  = rd0 ? mem_rd_data : rsp_data0_q;
    rsp_data1_d  = rd1 ? mem_rd_data : rsp_data1_q;
  end
  // Arbitration history and registered read responses; reset drops pending responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      rsp_valid0_q <= 1'b0;
      rsp_valid1_q <= 1'b0;
      rsp_data0_q  <= '0;
      rsp_data1_q  <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rsp_valid0_q <= rsp_valid0_d;
      rsp_valid1_q <= rsp_valid1_d;
      rsp_data0_q  <= rsp_data0_d;
      rsp_data1_q  <= rsp_data1_d;
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed checks of grant order, responses, backpressure and reset
module tb_ram_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mem_addr, mem_wr_data, mem_rd_data;
  logic        mem_wr_en;
  logic [31:0] ram [0:255];
  int          n_cmp = 0;
  int          n_err = 0;
  ram_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) p0_if ();
  ram_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) p1_if ();
  ram_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .p0(p0_if), .p1(p1_if),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en), .mem_rd_data(mem_rd_data)
  );
  always #5 clk = ~clk;
  assign mem_rd_data = ram[mem_addr[7:0]];
  always @(posedge clk) if (mem_wr_en) ram[mem_addr[7:0]] <= mem_wr_data;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic req0(input logic v, input logic wr, input logic [31:0] a, input logic [31:0] d);
    p0_if.req_valid = v; p0_if.req_wr_en = wr; p0_if.req_addr = a; p0_if.req_wr_data = d;
  endtask
  task automatic req1(input logic v, input logic wr, input logic [31:0] a, input logic [31:0] d);
    p1_if.req_valid = v; p1_if.req_wr_en = wr; p1_if.req_addr = a; p1_if.req_wr_data = d;
  endtask
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    ram[8'h04] = 32'h1111_1111;
    ram[8'h08] = 32'h2222_2222;
    p0_if.rsp_ready = 1'b1;
    p1_if.rsp_ready = 1'b1;
    req0(1'b1, 1'b0, 32'h4, 32'h0);
    req1(1'b1, 1'b0, 32'h8, 32'h0);
    step(); step();
    check("rst_p0_rsp_valid", {31'b0, p0_if.rsp_valid}, 32'd0);
    check("rst_p1_rsp_valid", {31'b0, p1_if.rsp_valid}, 32'd0);
    check("rst_mem_wr_en",    {31'b0, mem_wr_en}, 32'd0);
    check("rst_p0_req_ready", {31'b0, p0_if.req_ready}, 32'd0);
    check("rst_p1_req_ready", {31'b0, p1_if.req_ready}, 32'd0);
    check("rst_p0_rsp_data",  p0_if.rsp_data, 32'd0);
    check("rst_p1_rsp_data",  p1_if.rsp_data, 32'd0);
    check("rst_mem_addr",     mem_addr, 32'd0);
    req0(1'b0, 1'b0, 32'h0, 32'h0);
    req1(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
    rst_n = 1'b1;
    #1;
    check("wr_p1_req_ready", {31'b0, p1_if.req_ready}, 32'd1);
    check("wr_mem_wr_en",    {31'b0, mem_wr_en}, 32'd1);
    check("wr_mem_addr",     mem_addr, 32'h10);
    check("wr_mem_wr_data",  mem_wr_data, 32'hDEAD_BEEF);
    step();
    req1(1'b0, 1'b0, 32'h0, 32'h0);
    req0(1'b1, 1'b0, 32'h10, 32'h0);
    #1;
    check("rd_p0_req_ready", {31'b0, p0_if.req_ready}, 32'd1);
    check("rd_mem_wr_en",    {31'b0, mem_wr_en}, 32'd0);
    check("rd_p0_rsp_valid_early", {31'b0, p0_if.rsp_valid}, 32'd0);
    step();
    req0(1'b0, 1'b0, 32'h0, 32'h0);
    check("rd_p0_rsp_valid", {31'b0, p0_if.rsp_valid}, 32'd1);
    check("rd_p0_rsp_data",  p0_if.rsp_data, 32'hDEAD_BEEF);
    check("rd_p1_rsp_valid", {31'b0, p1_if.rsp_valid}, 32'd0);
    step();
    check("rd_p0_rsp_clear", {31'b0, p0_if.rsp_valid}, 32'd0);
    check("rd_p0_data_hold", p0_if.rsp_data, 32'hDEAD_BEEF);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    req0(1'b1, 1'b0, 32'h4, 32'h0);
    req1(1'b1, 1'b0, 32'h8, 32'h0);
    #1;
    for (int i = 0; i < 4; i++) begin
      check("cont_p0_req_ready", {31'b0, p0_if.req_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("cont_p1_req_ready", {31'b0, p1_if.req_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      step();
      check("cont_p0_rsp_valid", {31'b0, p0_if.rsp_valid}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("cont_p1_rsp_valid", {31'b0, p1_if.rsp_valid}, (i % 2 == 1) ? 32'd1 : 32'd0);
      check("cont_rsp_data", (i % 2 == 0) ? p0_if.rsp_data : p1_if.rsp_data,
            (i % 2 == 0) ? 32'h1111_1111 : 32'h2222_2222);
    end
    req1(1'b0, 1'b0, 32'h0, 32'h0);
    req0(1'b1, 1'b0, 32'h10, 32'h0);
    p0_if.rsp_ready = 1'b0;
    #1;
    check("bp_first_grant", {31'b0, p0_if.req_ready}, 32'd1);
    step();
    req0(1'b1, 1'b0, 32'h4, 32'h0);
    req1(1'b1, 1'b0, 32'h8, 32'h0);
    check("bp_p0_rsp_data_init", p0_if.rsp_data, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_p0_req_ready", {31'b0, p0_if.req_ready}, 32'd0);
      check("bp_p1_req_ready", {31'b0, p1_if.req_ready}, 32'd1);
      step();
      check("bp_p0_rsp_valid", {31'b0, p0_if.rsp_valid}, 32'd1);
      check("bp_p0_rsp_data",  p0_if.rsp_data, 32'hDEAD_BEEF);
      check("bp_p1_rsp_data",  p1_if.rsp_data, 32'h2222_2222);
    end
    req1(1'b0, 1'b0, 32'h0, 32'h0);
    p0_if.rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'b0, p0_if.req_ready}, 32'd1);
    step();
    check("bp_release_valid", {31'b0, p0_if.rsp_valid}, 32'd1);
    check("bp_release_data",  p0_if.rsp_data, 32'h1111_1111);
    p0_if.rsp_ready = 1'b0;
    req0(1'b1, 1'b1, 32'h20, 32'hCAFE_F00D);
    #1;
    check("wbp_p0_req_ready", {31'b0, p0_if.req_ready}, 32'd1);
    check("wbp_mem_wr_en",    {31'b0, mem_wr_en}, 32'd1);
    step();
    req0(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("wbp_mem_wr_en_off", {31'b0, mem_wr_en}, 32'd0);
    check("wbp_p0_rsp_valid",  {31'b0, p0_if.rsp_valid}, 32'd1);
    check("wbp_p0_rsp_data",   p0_if.rsp_data, 32'h1111_1111);
    req1(1'b1, 1'b0, 32'h20, 32'h0);
    step();
    req1(1'b0, 1'b0, 32'h0, 32'h0);
    p1_if.rsp_ready = 1'b0;
    check("wbp_readback", p1_if.rsp_data, 32'hCAFE_F00D);
    check("mr_p1_rsp_valid_pre", {31'b0, p1_if.rsp_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_p1_rsp_valid", {31'b0, p1_if.rsp_valid}, 32'd0);
    check("mr_p0_rsp_valid", {31'b0, p0_if.rsp_valid}, 32'd0);
    rst_n = 1'b1;
    p0_if.rsp_ready = 1'b1;
    p1_if.rsp_ready = 1'b1;
    req0(1'b1, 1'b0, 32'h4, 32'h0);
    req1(1'b1, 1'b0, 32'h8, 32'h0);
    #1;
    check("mr_first_p0", {31'b0, p0_if.req_ready}, 32'd1);
    check("mr_first_p1", {31'b0, p1_if.req_ready}, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter and sequencer that shares the single-port `RAM` between the instruction-fetch port (port 0) and the load/store port (port 1) of the multi-cycle MIPS core. It accepts at most one request per cycle with round-robin fairness. It drives the RAM address, write-data and write-enable lines. Read data is captured into a per-port registered response with a valid/ready handshake.

## Interface
- `DATA_WIDTH`, 32, RAM word width
- `ADDR_WIDTH`, 32, RAM address width

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `pN_req_valid`  in  1  port N (N = 0, 1) request present
- `pN_req_ready`  out  1  port N request accepted this cycle (combinational grant)
- `pN_req_addr`  in  ADDR_WIDTH  port N address
- `pN_req_wr_en`  in  1  1 = write, 0 = read
- `pN_req_wr_data`  in  DATA_WIDTH  port N write data
- `pN_rsp_valid`  out  1  port N read response available
- `pN_rsp_ready`  in  1  port N consumes response
- `pN_rsp_data`  out  DATA_WIDTH  port N read data
- `mem_addr`  out  ADDR_WIDTH  to RAM `addr`
- `mem_wr_data`  out  DATA_WIDTH  to RAM `wr_data`
- `mem_wr_en`  out  1  to RAM `wr_en`
- `mem_rd_data`  in  DATA_WIDTH  from RAM `rd_data` (combinational read)

## Operation
- **Eligibility.** Port N is eligible when `pN_req_valid` is 1 and either:
  - the request is a write, or
  - the response slot is free: `!pN_rsp_valid || pN_rsp_ready`.
- **Grant.**
  - Only one port is eligible: that port is granted.
  - Both ports are eligible: the port other than `last_grant` is granted.
  - No port is eligible: no grant.
  - `pN_req_ready` = grant to port N. It is never asserted for an ineligible port.
- **`last_grant`.** 1-bit register. Updated to the granted port on every grant and held when there is no grant.
- **RAM drive.**
  - On a grant, `mem_addr`, `mem_wr_data` and `mem_wr_en` are muxed combinationally from the granted port.
  - With no grant: `mem_wr_en` = 0, `mem_addr` = 0, `mem_wr_data` = 0.
- **Write.** The RAM commits the write at the grant edge. A write produces no response.
- **Read.**
  - `pN_rsp_data` <= `mem_rd_data` and `pN_rsp_valid` <= 1 at the grant edge.
- **Response clear.**
  - If `pN_rsp_valid && pN_rsp_ready` and there is no new read grant to N, `pN_rsp_valid` <= 0 at the edge. `pN_rsp_data` holds its value.
  - If consume and a new read grant to N occur in the same cycle, `pN_rsp_valid` stays 1 and the data is replaced.
- **Response hold.** `pN_rsp_data` is stable while `pN_rsp_valid && !pN_rsp_ready`.
- **Ordering.** A write granted in cycle N is visible to any read granted in cycle N+1 or later.

## Timing
- Reset values (asynchronous, on `rst_n` = 0):
  - `pN_rsp_valid` = 0, `pN_rsp_data` = 0.
  - `last_grant` = 1, so port 0 wins the first conflict.
  - `mem_*` and `pN_req_ready` follow the combinational rules above with no grant possible during reset, so all are 0.
- Read latency: request accepted in cycle N, response valid in cycle N+1.
- Throughput: one access per cycle across both ports. A port with back-to-back reads and `rsp_ready` held at 1 sustains 1 read per cycle when the other port is idle.
- Under continuous contention the ports alternate grants. Maximum wait is 1 cycle.
- Reset mid-operation drops pending responses. Any write whose grant edge has not yet occurred is not performed.
- Requesters hold `req_*` stable until `req_ready` is asserted. Per-port request order is preserved.

## Test plan
- **Reset values.** Assert `rst_n` = 0 with both ports requesting reads -> `p0_rsp_valid` = `p1_rsp_valid` = 0, `mem_wr_en` = 0, `p0_req_ready` = `p1_req_ready` = 0, `p0_rsp_data` = `p1_rsp_data` = 0.
- **Write then read.** Port 1 writes 0xDEADBEEF to address 0x10. Next cycle port 0 reads 0x10 -> `p0_rsp_valid` = 1 one cycle after the grant, `p0_rsp_data` = 0xDEADBEEF. Port 1 sees no response.
- **Contention.**
  - Both ports read continuously (p0 address 0x4, p1 address 0x8) with `rsp_ready` = 1 after reset.
  - Required grants: p0, p1, p0, p1.
  - Each port gets `rsp_valid` = 1 on alternating cycles with the correct data.
- **Backpressure.**
  - `p0_rsp_valid` = 1 with `p0_rsp_ready` = 0 for 3 cycles while port 0 requests another read.
  - Required: `p0_req_ready` = 0 for those 3 cycles and `p0_rsp_data` stable. Port 1 reads are granted meanwhile.
  - Releasing `p0_rsp_ready` -> `p0_req_ready` = 1 in the same cycle and new data appears on the next cycle.
- **Write under backpressure.** Port 0 response stalled, port 0 issues a write -> write granted, `mem_wr_en` = 1 for exactly one cycle, held response unchanged.
- **Mid-operation reset.** Assert `rst_n` while `p1_rsp_valid` = 1 -> `p1_rsp_valid` = 0 immediately. After release, the first conflict is granted to port 0.
